fip_32_cramer_solver: RTL and testbench
=======================================

FIP_32_CRAMER_SOLVER -- requirements
Module: fip_32_cramer_solver

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port i_a, input, signed [31:0] [2:0][2:0]: matrix A in Q16.16, i_a[r][c] is row r, column c.
REQ-004 SHALL have port i_b, input, signed [31:0] [2:0]: right-hand vector b in Q16.16.
REQ-005 SHALL have port i_valid, input, 1 bit: i_a and i_b hold a request.
REQ-006 SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port o_x, o_y, o_z, output, signed [31:0] each: solution of A*[x y z]^T = b in Q16.16.
REQ-008 SHALL have port o_singular, output, 1 bit: det(A) was zero.
REQ-009 SHALL have port o_overflow, output, 1 bit: some determinant or division overflowed.
REQ-010 SHALL have port o_valid, output, 1 bit: the result outputs are valid.
REQ-011 SHALL have port i_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-012 SHALL reuse one combinational fip_32_3b3_det instance and one fip_32_div instance.
REQ-013 Both instances SHALL be time-multiplexed by the FSM.
REQ-014 FSM states SHALL be IDLE, DET_A, DET_X, DET_Y, DET_Z, DIV_X, DIV_Y, DIV_Z, DONE.
REQ-015 o_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on an edge where state is IDLE and i_valid=1.
REQ-017 On accept, the block SHALL capture i_a and i_b into internal registers and go to DET_A.
REQ-018 Inputs SHALL be ignored after capture.
REQ-019 DET_A SHALL register det(A).
REQ-020 If det(A)==0, DET_A SHALL go to DONE with o_singular=1, o_x=o_y=o_z=0 and o_overflow=0.
REQ-021 If det(A)!=0, DET_A SHALL go to DET_X.
REQ-022 DET_X, DET_Y and DET_Z SHALL register the determinant of A with column 0, 1 and 2 respectively replaced by b.
REQ-023 Each state SHALL last one cycle, then advance to the next state.
REQ-024 DIV_X, DIV_Y and DIV_Z SHALL register det_X/det_A, det_Y/det_A and det_Z/det_A into o_x, o_y and o_z, one per cycle.
REQ-025 After DIV_Z, the FSM SHALL go to DONE.
REQ-026 Latency SHALL be exactly 7 cycles from the accept edge to o_valid=1 for a non-singular request.
REQ-027 Latency SHALL be exactly 1 cycle from the accept edge to o_valid=1 for a singular request.
REQ-028 o_valid SHALL be 1 only in DONE.
REQ-029 o_x, o_y, o_z, o_singular and o_overflow SHALL be stable while o_valid=1.
REQ-030 DONE SHALL go to IDLE on the edge where i_ready=1.
REQ-031 DONE SHALL hold indefinitely while i_ready=0.
REQ-032 i_valid arriving in any state other than IDLE SHALL not be accepted and SHALL cause no side effect.
REQ-033 o_overflow SHALL be sticky within a transaction: the OR of all det and div overflow flags.
REQ-034 o_overflow SHALL be cleared on accept.
REQ-035 The div underflow flag SHALL be ignored, since the divisor is nonzero by construction.
REQ-036 The 1-cycle DONE-to-IDLE turnaround SHALL be allowed, so back-to-back requests are spaced at least 9 cycles apart.

Reset
REQ-037 While i_rstn=0, the FSM SHALL be in IDLE.
REQ-038 While i_rstn=0, o_ready SHALL be 1.
REQ-039 While i_rstn=0, o_valid, o_singular and o_overflow SHALL be 0.
REQ-040 While i_rstn=0, o_x, o_y and o_z SHALL be 0.
REQ-041 While i_rstn=0, all captured operands and intermediate determinants SHALL be 0.
REQ-042 Reset asserted in any state SHALL abort the transaction immediately.
REQ-043 Reset release SHALL produce no o_valid without a new accept.

Configuration
REQ-044 SHALL support macro FIP_CRAMER_SATURATE_EN.
REQ-045 With FIP_CRAMER_SATURATE_EN defined, a quotient whose division overflowed SHALL be written as 32'h7FFFFFFF if the true sign is positive and 32'h80000000 if negative.
REQ-046 With FIP_CRAMER_SATURATE_EN defined, the sign used for saturation SHALL be det_k[31] XOR det_A[31].
REQ-047 With FIP_CRAMER_SATURATE_EN undefined, the raw fip_32_div quotient SHALL be written unchanged.
REQ-048 o_overflow SHALL behave identically with or without FIP_CRAMER_SATURATE_EN.

Verification
REQ-049 Scenario: A=identity, b=(0x10000, 0x20000, 0x30000) -> o_valid 7 cycles after accept; x=0x10000, y=0x20000, z=0x30000; singular=0; overflow=0.
REQ-050 Scenario: A=diag(0x20000), b=(0x10000, 0xFFFF0000, 0x40000) -> x=0x8000, y=0xFFFF8000, z=0x20000; overflow=0.
REQ-051 Scenario: A rows (1,2,3),(4,5,6),(7,8,9) in Q16.16 -> o_valid 1 cycle after accept; singular=1; x=y=z=0.
REQ-052 Scenario: A=diag(0x4000), b=(0x7FFF0000, 0, 0) -> overflow=1; with FIP_CRAMER_SATURATE_EN defined, x=0x7FFFFFFF.
REQ-053 Scenario: identity case with i_ready held 0 for 5 cycles after o_valid -> outputs stable; o_ready=0 and i_valid ignored until the release edge; IDLE one cycle later.
REQ-054 Scenario: i_rstn pulsed low during DIV_Y -> all outputs 0 and o_ready=1 immediately; no o_valid follows.

Source files
------------

// File: rtl/fip_32_cramer_solver.sv
// ---------------------------------------------------------------------------
// fip_32_cramer_solver
//   Solves A * [x y z]^T = b for a 3x3 system in Q16.16 using Cramer's rule.
//   One combinational 3x3 determinant unit and one divider are shared and
//   time-multiplexed by a small FSM:
//     IDLE -> DET_A -> DET_X -> DET_Y -> DET_Z -> DIV_X -> DIV_Y -> DIV_Z -> DONE
//   A zero det(A) short-cuts DET_A -> DONE with o_singular=1.
//
// Ports
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_a[r][c], i_b[r]    Q16.16 matrix / right-hand side, captured on accept
//   i_valid / o_ready    request handshake (accept when IDLE and i_valid=1)
//   o_x, o_y, o_z        Q16.16 solution
//   o_singular           det(A) was zero (solution forced to zero)
//   o_overflow           sticky OR of every determinant / division overflow
//   o_valid / i_ready    result handshake (held in DONE until i_ready=1)
//
// Configuration
//   FIP_CRAMER_SATURATE_EN  when defined, an overflowed quotient is written as
//                           the saturated value of its true sign instead of
//                           the raw (wrapped) divider result.
//
// Sub-modules in this file
//   fip_32_3b3_det  Q16.16 determinant, exact internally, floor to Q16.16,
//                   saturates and flags overflow when out of range.
//   fip_32_div      Q16.16 divide, truncates toward zero, raw wrapped
//                   quotient plus overflow / underflow flags.
// ---------------------------------------------------------------------------

module fip_32_3b3_det (
    input  logic        [2:0][2:0][31:0] m,
    output logic signed [31:0]           det,
    output logic                         overflow
);
    function automatic logic signed [99:0] ext(input logic [31:0] v);
        return {{68{v[31]}}, v};
    endfunction

    // Exact determinant carries 48 fraction bits; dropping 32 leaves Q16.16.
    function automatic logic signed [67:0] det_scaled(input logic [2:0][2:0][31:0] mm);
        logic signed [99:0] s;
        s = ext(mm[0][0]) * (ext(mm[1][1]) * ext(mm[2][2]) - ext(mm[1][2]) * ext(mm[2][1]))
          - ext(mm[0][1]) * (ext(mm[1][0]) * ext(mm[2][2]) - ext(mm[1][2]) * ext(mm[2][0]))
          + ext(mm[0][2]) * (ext(mm[1][0]) * ext(mm[2][1]) - ext(mm[1][1]) * ext(mm[2][0]));
        return 68'(s >>> 32);
    endfunction

    logic signed [67:0] scaled;

    always_comb begin
        scaled   = det_scaled(m);
        overflow = !((&scaled[67:31]) || (~|scaled[67:31]));
        // Saturating keeps an out-of-range determinant from wrapping to zero
        // and being mistaken for a singular matrix.
        if (overflow)
            det = scaled[67] ? 32'sh80000000 : 32'sh7FFFFFFF;
        else
            det = scaled[31:0];
    end
endmodule

module fip_32_div (
    input  logic signed [31:0] num,
    input  logic signed [31:0] den,
    output logic signed [31:0] quo,
    output logic               overflow,
    output logic               underflow
);
    logic signed [63:0] n_ext;
    logic signed [63:0] d_ext;
    logic signed [63:0] q;

    always_comb begin
        n_ext = {{16{num[31]}}, num, 16'h0000};
        d_ext = {{32{den[31]}}, den};
        q     = '0;
        if (den != 32'sd0)
            q = n_ext / d_ext;
        overflow  = (den == 32'sd0) || !((&q[63:31]) || (~|q[63:31]));
        underflow = (num != 32'sd0) && (q == 64'sd0);
        quo       = q[31:0];
    end
endmodule

module fip_32_cramer_solver (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic signed [2:0][2:0][31:0] i_a,
    input  logic signed [2:0][31:0]      i_b,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic signed [31:0]           o_x,
    output logic signed [31:0]           o_y,
    output logic signed [31:0]           o_z,
    output logic                         o_singular,
    output logic                         o_overflow,
    output logic                         o_valid,
    input  logic                         i_ready
);
    typedef enum logic [3:0] {
        IDLE, DET_A, DET_X, DET_Y, DET_Z, DIV_X, DIV_Y, DIV_Z, DONE
    } state_t;

    state_t state_reg, state_next;

    logic        [2:0][2:0][31:0] a_reg;
    logic        [2:0][31:0]      b_reg;
    logic signed [31:0]           det_a_reg, det_x_reg, det_y_reg, det_z_reg;
    logic signed [31:0]           x_reg, y_reg, z_reg;
    logic                         singular_reg, overflow_reg;

    // Determinant unit input: A with column col_sel replaced by b
    // (col_sel = 3 leaves A untouched).
    logic        [1:0]            col_sel;
    logic        [2:0][2:0][31:0] det_m;
    logic signed [31:0]           det_val;
    logic                         det_ovf;

    logic signed [31:0]           div_num;
    logic signed [31:0]           div_quo;
    logic                         div_ovf;
    logic signed [31:0]           quo_final;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            for (genvar gj = 0; gj < 3; gj++) begin : g_col
                assign det_m[gi][gj] = (col_sel == 2'(gj)) ? b_reg[gi] : a_reg[gi][gj];
            end
        end
    endgenerate

    fip_32_3b3_det u_det (
        .m        (det_m),
        .det      (det_val),
        .overflow (det_ovf)
    );

    // The divisor is det(A), already known to be nonzero, so underflow
    // carries no information here and is left unconnected.
    fip_32_div u_div (
        .num       (div_num),
        .den       (det_a_reg),
        .quo       (div_quo),
        .overflow  (div_ovf),
        .underflow ()
    );

    always_comb begin
        col_sel = 2'd3;
        div_num = '0;
        case (state_reg)
            DET_X:   col_sel = 2'd0;
            DET_Y:   col_sel = 2'd1;
            DET_Z:   col_sel = 2'd2;
            DIV_X:   div_num = det_x_reg;
            DIV_Y:   div_num = det_y_reg;
            DIV_Z:   div_num = det_z_reg;
            default: ;
        endcase
    end

`ifdef FIP_CRAMER_SATURATE_EN
    // True sign of the quotient is the XOR of numerator and divisor signs.
    always_comb begin
        quo_final = div_quo;
        if (div_ovf)
            quo_final = (div_num[31] ^ det_a_reg[31]) ? 32'sh80000000 : 32'sh7FFFFFFF;
    end
`else
    always_comb begin
        quo_final = div_quo;
    end
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_valid) state_next = DET_A;
            DET_A:   state_next = (det_val == 32'sd0) ? DONE : DET_X;
            DET_X:   state_next = DET_Y;
            DET_Y:   state_next = DET_Z;
            DET_Z:   state_next = DIV_X;
            DIV_X:   state_next = DIV_Y;
            DIV_Y:   state_next = DIV_Z;
            DIV_Z:   state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Datapath: each state writes exactly one register group.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            a_reg        <= '0;
            b_reg        <= '0;
            det_a_reg    <= '0;
            det_x_reg    <= '0;
            det_y_reg    <= '0;
            det_z_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            z_reg        <= '0;
            singular_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        a_reg        <= i_a;
                        b_reg        <= i_b;
                        det_a_reg    <= '0;
                        det_x_reg    <= '0;
                        det_y_reg    <= '0;
                        det_z_reg    <= '0;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        z_reg        <= '0;
                        singular_reg <= 1'b0;
                        overflow_reg <= 1'b0;
                    end
                end
                DET_A: begin
                    det_a_reg    <= det_val;
                    singular_reg <= (det_val == 32'sd0);
                    overflow_reg <= overflow_reg | det_ovf;
                end
                DET_X: begin
                    det_x_reg    <= det_val;
                    overflow_reg <= overflow_reg | det_ovf;
                end
                DET_Y: begin
                    det_y_reg    <= det_val;
                    overflow_reg <= overflow_reg | det_ovf;
                end
                DET_Z: begin
                    det_z_reg    <= det_val;
                    overflow_reg <= overflow_reg | det_ovf;
                end
                DIV_X: begin
                    x_reg        <= quo_final;
                    overflow_reg <= overflow_reg | div_ovf;
                end
                DIV_Y: begin
                    y_reg        <= quo_final;
                    overflow_reg <= overflow_reg | div_ovf;
                end
                DIV_Z: begin
                    z_reg        <= quo_final;
                    overflow_reg <= overflow_reg | div_ovf;
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = (state_reg == IDLE);
    assign o_valid    = (state_reg == DONE);
    assign o_x        = x_reg;
    assign o_y        = y_reg;
    assign o_z        = z_reg;
    assign o_singular = singular_reg;
    assign o_overflow = overflow_reg;
endmodule

// File: tb/tb_fip_32_cramer_solver.sv
// ---------------------------------------------------------------------------
// tb_fip_32_cramer_solver
//   Self-checking bench for fip_32_cramer_solver. Expected results come from
//   an exact wide-integer Cramer's-rule model (cofactor expansion, floor to
//   Q16.16, truncating division) and from hand-computed scenario constants.
//   Honours FIP_CRAMER_SATURATE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_fip_32_cramer_solver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstn;
    logic [2:0][2:0][31:0]  a_in;
    logic [2:0][31:0]       b_in;
    logic                   valid_in;
    logic                   ready_out;
    logic signed [31:0]     x_out, y_out, z_out;
    logic                   sing_out, ovf_out, valid_out;
    logic                   ready_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    fip_32_cramer_solver dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_a        (a_in),
        .i_b        (b_in),
        .i_valid    (valid_in),
        .o_ready    (ready_out),
        .o_x        (x_out),
        .o_y        (y_out),
        .o_z        (z_out),
        .o_singular (sing_out),
        .o_overflow (ovf_out),
        .o_valid    (valid_out),
        .i_ready    (ready_in)
    );

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    localparam logic signed [127:0] QMAX = 128'sd2147483647;
    localparam logic signed [127:0] QMIN = -128'sd2147483648;

    function automatic logic signed [127:0] wx(input logic [31:0] v);
        return {{96{v[31]}}, v};
    endfunction

    function automatic logic signed [127:0] det_exact(input logic [2:0][2:0][31:0] m);
        logic signed [127:0] acc;
        logic signed [127:0] minor;
        int c1, c2;
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            c1 = (c == 0) ? 1 : 0;
            c2 = (c == 2) ? 1 : 2;
            minor = wx(m[1][c1]) * wx(m[2][c2]) - wx(m[1][c2]) * wx(m[2][c1]);
            if (c == 1) acc = acc - wx(m[0][c]) * minor;
            else        acc = acc + wx(m[0][c]) * minor;
        end
        return acc;
    endfunction

    task automatic to_q(input logic signed [127:0] full, output logic [31:0] d, output bit ovf);
        logic signed [127:0] s;
        s = full >>> 32;
        ovf = 1'b0;
        if (s > QMAX)      begin d = 32'h7FFFFFFF; ovf = 1'b1; end
        else if (s < QMIN) begin d = 32'h80000000; ovf = 1'b1; end
        else               d = s[31:0];
    endtask

    task automatic model_solve(input logic [2:0][2:0][31:0] ma, input logic [2:0][31:0] vb,
                               output logic [31:0] ex, output logic [31:0] ey,
                               output logic [31:0] ez, output bit esing, output bit eovf);
        logic [2:0][2:0][31:0] mk;
        logic [31:0] da, dk;
        logic [31:0] res [3];
        logic signed [127:0] q;
        bit o;
        to_q(det_exact(ma), da, eovf);
        esing = (da == 32'h0);
        res[0] = 0; res[1] = 0; res[2] = 0;
        if (esing) begin
            eovf = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                mk = ma;
                for (int r = 0; r < 3; r++) mk[r][k] = vb[r];
                to_q(det_exact(mk), dk, o);
                eovf |= o;
                q = (wx(dk) * 128'sd65536) / wx(da);
                if (q > QMAX || q < QMIN) begin
                    eovf = 1'b1;
`ifdef FIP_CRAMER_SATURATE_EN
                    res[k] = (q < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`else
                    res[k] = q[31:0];
`endif
                end else begin
                    res[k] = q[31:0];
                end
            end
        end
        ex = res[0]; ey = res[1]; ez = res[2];
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [2:0][2:0][31:0] diag(input logic [31:0] v);
        logic [2:0][2:0][31:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) m[i][i] = v;
        return m;
    endfunction

    function automatic logic [31:0] rnd_q();
        int v;
        v = int'($urandom_range(32'h80000, 0)) - 32'sh40000;
        return v;
    endfunction

    // Waits for o_ready, presents a request, and returns the number of edges
    // from the accept edge to o_valid (capped at 20). Operands are scrambled
    // right after the accept edge.
    task automatic send(input logic [2:0][2:0][31:0] ma, input logic [2:0][31:0] vb,
                        output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_out && guard < 50) begin @(negedge clk); guard++; end
        a_in = ma; b_in = vb; valid_in = 1'b1;
        @(posedge clk);
        accept_cyc = cyc;
        #1;
        valid_in = 1'b0;
        for (int r = 0; r < 3; r++) begin
            b_in[r] = $urandom;
            for (int c = 0; c < 3; c++) a_in[r][c] = $urandom;
        end
        lat = 0;
        while (!valid_out && lat < 20) begin @(posedge clk); #1; lat++; end
        $display("txn accept@%0d lat=%0d x=%h y=%h z=%h sing=%b ovf=%b",
                 accept_cyc, lat, x_out, y_out, z_out, sing_out, ovf_out);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; valid_in = 1'b1; ready_in = 1'b1; a_in = diag(32'h10000); b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
        checks++;
        if ({valid_out, sing_out, ovf_out} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {valid_out, sing_out, ovf_out});
        end
        checks++;
        if ({x_out, y_out, z_out} !== 96'h0) begin
            errors++; $display("FAIL reset_xyz: got %h %h %h expected 0", x_out, y_out, z_out);
        end
        @(negedge clk);
        valid_in = 1'b0;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_release: got valid=%b ready=%b expected 0/1", valid_out, ready_out);
        end
    endtask

    task automatic test_identity();
        int lat;
        logic [2:0][31:0] vb;
        vb[0] = 32'h10000; vb[1] = 32'h20000; vb[2] = 32'h30000;
        send(diag(32'h10000), vb, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL identity_latency: got %0d expected 7", lat); end
        checks++;
        if ({x_out, y_out, z_out} !== {32'h10000, 32'h20000, 32'h30000}) begin
            errors++; $display("FAIL identity_xyz: got %h %h %h expected 10000 20000 30000", x_out, y_out, z_out);
        end
        checks++;
        if ({sing_out, ovf_out} !== 2'b00) begin
            errors++; $display("FAIL identity_flags: got %b expected 00", {sing_out, ovf_out});
        end
    endtask

    task automatic test_diag();
        int lat;
        logic [2:0][31:0] vb;
        vb[0] = 32'h10000; vb[1] = 32'hFFFF0000; vb[2] = 32'h40000;
        send(diag(32'h20000), vb, lat);
        checks++;
        if ({x_out, y_out, z_out} !== {32'h8000, 32'hFFFF8000, 32'h20000}) begin
            errors++; $display("FAIL diag_xyz: got %h %h %h expected 8000 ffff8000 20000", x_out, y_out, z_out);
        end
        checks++;
        if ({lat, sing_out, ovf_out} !== {32'd7, 2'b00}) begin
            errors++; $display("FAIL diag_lat_flags: got lat=%0d sing=%b ovf=%b expected 7/0/0", lat, sing_out, ovf_out);
        end
    endtask

    task automatic test_singular();
        int lat;
        logic [2:0][2:0][31:0] ma;
        logic [2:0][31:0] vb;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) ma[r][c] = (3 * r + c + 1) << 16;
        vb[0] = 32'h10000; vb[1] = 32'h20000; vb[2] = 32'h30000;
        send(ma, vb, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL singular_latency: got %0d expected 1", lat); end
        checks++;
        if ({sing_out, ovf_out} !== 2'b10) begin
            errors++; $display("FAIL singular_flags: got %b expected 10", {sing_out, ovf_out});
        end
        checks++;
        if ({x_out, y_out, z_out} !== 96'h0) begin
            errors++; $display("FAIL singular_xyz: got %h %h %h expected 0", x_out, y_out, z_out);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [2:0][31:0] vb;
        logic [31:0] exp_x;
        vb[0] = 32'h7FFF0000; vb[1] = 32'h0; vb[2] = 32'h0;
`ifdef FIP_CRAMER_SATURATE_EN
        exp_x = 32'h7FFFFFFF;
`else
        exp_x = 32'hFFFC0000;
`endif
        send(diag(32'h4000), vb, lat);
        checks++;
        if (ovf_out !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b expected 1", ovf_out); end
        checks++;
        if ({x_out, y_out, z_out} !== {exp_x, 64'h0}) begin
            errors++; $display("FAIL overflow_xyz: got %h %h %h expected %h 0 0", x_out, y_out, z_out, exp_x);
        end
        // The next accept must clear the sticky flag.
        vb[0] = 32'h10000;
        send(diag(32'h10000), vb, lat);
        checks++;
        if (ovf_out !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", ovf_out); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2:0][31:0] vb;
        logic [97:0] held;
        vb[0] = 32'h10000; vb[1] = 32'h20000; vb[2] = 32'h30000;
        ready_in = 1'b0;
        send(diag(32'h10000), vb, lat);
        held = {x_out, y_out, z_out, sing_out, ovf_out};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            a_in = diag(32'h30000);
            @(posedge clk);
            #1;
            checks++;
            if ({valid_out, ready_out} !== 2'b10 || {x_out, y_out, z_out, sing_out, ovf_out} !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b out=%h expected valid=1 ready=0 out=%h",
                         i, valid_out, ready_out, {x_out, y_out, z_out, sing_out, ovf_out}, held);
            end
        end
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        checks++;
        if ({valid_out, ready_out} !== 2'b01) begin
            errors++; $display("FAIL release_idle: got valid=%b ready=%b expected 0/1", valid_out, ready_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({valid_out, ready_out} !== 2'b01) begin
            errors++; $display("FAIL release_no_accept: got valid=%b ready=%b expected 0/1", valid_out, ready_out);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        a_in = diag(32'h10000);
        b_in[0] = 32'h10000; b_in[1] = 32'h20000; b_in[2] = 32'h30000;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (x_out !== 32'h10000) begin errors++; $display("FAIL mid_pre_x: got %h expected 10000", x_out); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({x_out, y_out, z_out, sing_out, ovf_out, valid_out, ready_out} !== {96'h0, 4'b0001}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got x=%h y=%h z=%h s=%b o=%b v=%b r=%b expected zeros, ready=1",
                     x_out, y_out, z_out, sing_out, ovf_out, valid_out, ready_out);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (valid_out) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_valid: got %b expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat, c1;
        logic [2:0][31:0] vb;
        vb[0] = 32'h10000; vb[1] = 32'h10000; vb[2] = 32'h10000;
        ready_in = 1'b1;
        send(diag(32'h10000), vb, lat);
        c1 = accept_cyc;
        send(diag(32'h20000), vb, lat);
        checks++;
        if (accept_cyc - c1 !== 9) begin
            errors++; $display("FAIL back_to_back_spacing: got %0d expected 9", accept_cyc - c1);
        end
        checks++;
        if ({x_out, y_out, z_out} !== {32'h8000, 32'h8000, 32'h8000}) begin
            errors++; $display("FAIL back_to_back_xyz: got %h %h %h expected 8000 x3", x_out, y_out, z_out);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0][2:0][31:0] ma;
        logic [2:0][31:0] vb;
        logic [31:0] ex, ey, ez;
        bit es, eo;
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 3; r++) begin
                vb[r] = rnd_q();
                for (int c = 0; c < 3; c++) ma[r][c] = rnd_q();
            end
            if (t % 5 == 0)
                for (int c = 0; c < 3; c++) ma[2][c] = ma[0][c] + ma[1][c];
            model_solve(ma, vb, ex, ey, ez, es, eo);
            send(ma, vb, lat);
            checks++;
            if (lat !== (es ? 1 : 7)) begin
                errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, es ? 1 : 7);
            end
            checks++;
            if ({x_out, y_out, z_out, sing_out, ovf_out} !== {ex, ey, ez, es, eo}) begin
                errors++;
                $display("FAIL rand%0d_result: got %h %h %h s=%b o=%b expected %h %h %h s=%b o=%b",
                         t, x_out, y_out, z_out, sing_out, ovf_out, ex, ey, ez, es, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_diag();
        test_singular();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
